// File: rtl/vga_layer_pkg.sv
// Shared constants for the VGA layer path: tile IDs, tile bitmap bases,
// screen size and the packed sprite attribute record.
package vga_layer_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [3:0] T_EMPTY   = 4'd0;
    localparam logic [3:0] T_SPIKE   = 4'd1;
    localparam logic [3:0] T_GATE_1  = 4'd2;
    localparam logic [3:0] T_GATE_2  = 4'd3;
    localparam logic [3:0] T_GATE_3  = 4'd4;
    localparam logic [3:0] T_PLATE_1 = 4'd5;
    localparam logic [3:0] T_PLATE_2 = 4'd6;
    localparam logic [3:0] T_PLATE_3 = 4'd7;
    localparam logic [3:0] T_EXIT    = 4'd8;
    localparam logic [3:0] T_WALL    = 4'd9;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] frame;
        logic       moving;
        logic       flip;
        logic       en;
    } spr_attr_t;

    localparam int SPR_ATTR_W = $bits(spr_attr_t);

    function automatic logic [16:0] tile_base(input logic [3:0] id);
        case (id)
            T_WALL, T_PLATE_1, T_PLATE_2, T_PLATE_3: tile_base = 17'd0;
            T_EXIT:                                  tile_base = 17'd11264;
            T_GATE_1, T_GATE_2, T_GATE_3:            tile_base = 17'd12288;
            T_SPIKE:                                 tile_base = 17'd23552;
            default:                                 tile_base = 17'd0;
        endcase
    endfunction

    function automatic spr_attr_t spr_reset(input int idx);
        spr_attr_t a;
        a.x      = 10'd32;
        a.y      = 10'(320 + 96 * idx);
        a.frame  = 3'd0;
        a.moving = 1'b0;
        a.flip   = 1'b0;
        a.en     = 1'b1;
        return a;
    endfunction

endpackage

// File: rtl/vga_layer_addr_gen_spr.sv
// One sprite: inset hit-box test and the registered strip address of the
// scan point inside that sprite's animation strip.
module spr_addr_calc
    import vga_layer_pkg::*;
#(
    parameter int                SPR_W       = 32,
    parameter int                SPR_H       = 32,
    parameter int                HIT_L       = 3,
    parameter int                HIT_R       = 3,
    parameter int                HIT_T       = 5,
    parameter int                ADDR_W      = 17,
    parameter int                IDLE_FRAMES = 4,
    parameter int                WALK_FRAMES = 6,
    parameter logic [ADDR_W-1:0] IDLE_BASE   = '0,
    parameter logic [ADDR_W-1:0] WALK_BASE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            i_h,
    input  logic [9:0]            i_v,
    input  logic                  i_vis,
    input  logic [SPR_ATTR_W-1:0] i_attr,
    output logic                  o_hit,
    output logic [ADDR_W-1:0]     o_addr
);

    localparam logic [10:0] L_X_LO = 11'(HIT_L);
    localparam logic [10:0] L_X_HI = 11'(SPR_W - HIT_R);
    localparam logic [10:0] L_Y_LO = 11'(HIT_T);
    localparam logic [10:0] L_Y_HI = 11'(SPR_H);

    spr_attr_t         w_attr;
    logic [10:0]       w_h, w_v, w_x, w_y, w_dx, w_dy;
    logic              w_hit;
    logic [2:0]        w_f;
    logic [ADDR_W-1:0] w_base, w_strip_w, w_col, w_lx, w_addr;

    assign w_attr = i_attr;

    // 11-bit compares keep a sprite parked near x=1023 from wrapping onto h=0.
    assign w_h  = {1'b0, i_h};
    assign w_v  = {1'b0, i_v};
    assign w_x  = {1'b0, w_attr.x};
    assign w_y  = {1'b0, w_attr.y};
    assign w_dx = w_h - w_x;
    assign w_dy = w_v - w_y;

    assign w_hit = i_vis && w_attr.en
                && (w_h >= w_x + L_X_LO) && (w_h < w_x + L_X_HI)
                && (w_v >= w_y + L_Y_LO) && (w_v < w_y + L_Y_HI);

    always_comb begin
        w_base    = IDLE_BASE;
        w_strip_w = ADDR_W'(IDLE_FRAMES * SPR_W);
        w_f       = (int'(w_attr.frame) < IDLE_FRAMES) ? w_attr.frame : 3'd0;
        if (w_attr.moving) begin
            w_base    = WALK_BASE;
            w_strip_w = ADDR_W'(WALK_FRAMES * SPR_W);
            w_f       = (int'(w_attr.frame) < WALK_FRAMES) ? w_attr.frame : 3'd0;
        end
        w_col = w_attr.flip ? ADDR_W'(SPR_W - 1) - ADDR_W'(w_dx) : ADDR_W'(w_dx);
        w_lx  = w_col + ADDR_W'(w_f) * ADDR_W'(SPR_W);
    end

    assign w_addr = w_base + ADDR_W'(w_dy) * w_strip_w + w_lx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_hit  <= 1'b0;
            o_addr <= '0;
        end else begin
            o_hit  <= w_hit;
            o_addr <= w_addr;
        end
    end

endmodule

// File: rtl/vga_layer_addr_gen.sv
// Per-pixel BRAM address generator for the tile map plus NUM_SPR sprites,
// with side-band flags delayed to line up with the BRAM read data.
module vga_layer_addr_gen
    import vga_layer_pkg::*;
#(
    parameter int NUM_SPR     = 2,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int TILE_SHIFT  = 5,
    parameter int MAP_COLS    = 20,
    parameter int MAP_ROWS    = 15,
    parameter int TID_W       = 4,
    parameter int ADDR_W      = 17,
    parameter int MEM_LAT     = 2,
    parameter int IDLE_FRAMES = 4,
    parameter int WALK_FRAMES = 6,
    parameter logic [ADDR_W*NUM_SPR-1:0] SPR_IDLE_BASE = {ADDR_W'(13312), ADDR_W'(1024)},
    parameter logic [ADDR_W*NUM_SPR-1:0] SPR_WALK_BASE = {ADDR_W'(17408), ADDR_W'(5120)},
    parameter int HIT_L       = 3,
    parameter int HIT_R       = 3,
    parameter int HIT_T       = 5,
    localparam int SEL_W      = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int MAP_CELLS  = MAP_COLS * MAP_ROWS,
    localparam int MAP_AW     = $clog2(MAP_CELLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           h_cnt,
    input  logic [9:0]           v_cnt,
    input  logic                 frame_start,
    input  logic                 spr_we,
    input  logic [SEL_W-1:0]     spr_sel,
    input  logic [9:0]           spr_x,
    input  logic [9:0]           spr_y,
    input  logic [2:0]           spr_frame,
    input  logic                 spr_moving,
    input  logic                 spr_flip,
    input  logic                 spr_en,
    input  logic                 map_we,
    input  logic [MAP_AW-1:0]    map_waddr,
    input  logic [TID_W-1:0]     map_wdata,
    input  logic [2**TID_W-1:0]  tile_hide,
    output logic [ADDR_W-1:0]    pixel_addr,
    output logic                 out_show,
    output logic [TID_W-1:0]     out_tile_id,
    output logic [NUM_SPR-1:0]   out_spr_hit
);

    spr_attr_t r_pend [NUM_SPR];
    spr_attr_t r_act  [NUM_SPR];
    spr_attr_t w_pend_nxt [NUM_SPR];

    // A write landing with frame_start is folded into the commit.
    always_comb begin
        for (int i = 0; i < NUM_SPR; i++) begin
            w_pend_nxt[i] = r_pend[i];
            if (spr_we && int'(spr_sel) == i)
                w_pend_nxt[i] = {spr_x, spr_y, spr_frame, spr_moving, spr_flip, spr_en};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                r_pend[i] <= spr_reset(i);
                r_act[i]  <= spr_reset(i);
            end
        end else begin
            for (int i = 0; i < NUM_SPR; i++) begin
                r_pend[i] <= w_pend_nxt[i];
                if (frame_start) r_act[i] <= w_pend_nxt[i];
            end
        end
    end

    logic              w_vis;
    logic [MAP_AW-1:0] w_map_raddr;
    logic [TID_W-1:0]  r_map [MAP_CELLS];

    assign w_vis       = (int'(h_cnt) < SCREEN_W) && (int'(v_cnt) < SCREEN_H);
    assign w_map_raddr = w_vis ? MAP_AW'(v_cnt[9:TILE_SHIFT]) * MAP_AW'(MAP_COLS)
                                 + MAP_AW'(h_cnt[9:TILE_SHIFT])
                               : '0;

    // Map RAM has no reset so level data survives rst.
    always_ff @(posedge clk) begin
        if (map_we && int'(map_waddr) < MAP_CELLS)
            r_map[map_waddr] <= map_wdata;
    end

    logic                  r_vis;
    logic [TILE_SHIFT-1:0] r_h_lo, r_v_lo;
    logic [TID_W-1:0]      r_tile;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vis  <= 1'b0;
            r_h_lo <= '0;
            r_v_lo <= '0;
            r_tile <= '0;
        end else begin
            r_vis  <= w_vis;
            r_h_lo <= h_cnt[TILE_SHIFT-1:0];
            r_v_lo <= v_cnt[TILE_SHIFT-1:0];
            r_tile <= r_map[w_map_raddr];
        end
    end

    logic [NUM_SPR-1:0] w_hits;
    logic [ADDR_W-1:0]  w_spr_addrs [NUM_SPR];

    // Base lists are written in sprite order: the leftmost entry is sprite 0.
    for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr
        localparam int SLICE = NUM_SPR - 1 - gi;
        spr_addr_calc #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .HIT_L      (HIT_L),
            .HIT_R      (HIT_R),
            .HIT_T      (HIT_T),
            .ADDR_W     (ADDR_W),
            .IDLE_FRAMES(IDLE_FRAMES),
            .WALK_FRAMES(WALK_FRAMES),
            .IDLE_BASE  (SPR_IDLE_BASE[SLICE*ADDR_W +: ADDR_W]),
            .WALK_BASE  (SPR_WALK_BASE[SLICE*ADDR_W +: ADDR_W])
        ) u_calc (
            .clk   (clk),
            .rst   (rst),
            .i_h   (h_cnt),
            .i_v   (v_cnt),
            .i_vis (w_vis),
            .i_attr(r_act[gi]),
            .o_hit (w_hits[gi]),
            .o_addr(w_spr_addrs[gi])
        );
    end

    logic [TID_W-1:0]  w_tile_id;
    logic              w_tile_vis, w_show;
    logic [ADDR_W-1:0] w_tile_addr, w_spr_addr, w_addr_nxt;

    always_comb begin
        w_tile_id   = r_vis ? r_tile : TID_W'(T_EMPTY);
        w_tile_vis  = (w_tile_id != TID_W'(T_EMPTY)) && !tile_hide[w_tile_id];
        w_tile_addr = ADDR_W'(tile_base(4'(w_tile_id))) + ADDR_W'({r_v_lo, r_h_lo});
        w_spr_addr  = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--)
            if (w_hits[i]) w_spr_addr = w_spr_addrs[i];
        w_show      = w_tile_vis || (|w_hits);
        w_addr_nxt  = w_tile_vis ? w_tile_addr : ((|w_hits) ? w_spr_addr : '0);
    end

    logic               r_sb_show [MEM_LAT+1];
    logic [TID_W-1:0]   r_sb_tile [MEM_LAT+1];
    logic [NUM_SPR-1:0] r_sb_hit  [MEM_LAT+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr <= '0;
            for (int i = 0; i <= MEM_LAT; i++) begin
                r_sb_show[i] <= 1'b0;
                r_sb_tile[i] <= '0;
                r_sb_hit[i]  <= '0;
            end
        end else begin
            pixel_addr   <= w_addr_nxt;
            r_sb_show[0] <= w_show;
            r_sb_tile[0] <= w_tile_id;
            r_sb_hit[0]  <= w_hits;
            for (int i = 1; i <= MEM_LAT; i++) begin
                r_sb_show[i] <= r_sb_show[i-1];
                r_sb_tile[i] <= r_sb_tile[i-1];
                r_sb_hit[i]  <= r_sb_hit[i-1];
            end
        end
    end

    assign out_show    = r_sb_show[MEM_LAT];
    assign out_tile_id = r_sb_tile[MEM_LAT];
    assign out_spr_hit = r_sb_hit[MEM_LAT];

endmodule
